// File: rtl/bus_trace_fifo_if.sv
// Capture/pop/inspect bundle between the processor-side driver and the trace FIFO.
interface bus_trace_fifo_if #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 16,
   parameter int TAG_WIDTH = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                 capture;
   logic [WIDTH-1:0]     cap_data;
   logic [TAG_WIDTH-1:0] cap_tag;
   logic                 pop_btn;
   logic                 clear;
   logic [WIDTH-1:0]     head_data;
   logic [TAG_WIDTH-1:0] head_tag;
   logic [CW-1:0]        count;
   logic                 empty;
   logic                 full;
   logic                 overflow;

   modport master (
      output capture, cap_data, cap_tag, pop_btn, clear,
      input  head_data, head_tag, count, empty, full, overflow
   );

   modport slave (
      input  capture, cap_data, cap_tag, pop_btn, clear,
      output head_data, head_tag, count, empty, full, overflow
   );
endinterface

// File: rtl/bus_trace_fifo.sv
// Trace FIFO: stores {tag,data} on each capture, pops on a button rising edge; capture lands at the next edge.
// No backpressure: captures into a full queue are dropped and flagged sticky in overflow unless a pop frees a slot that cycle.
module bus_trace_fifo #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 16,
   parameter int TAG_WIDTH = 5
) (
   input logic              clk,
   input logic              rst,
   bus_trace_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = WIDTH + TAG_WIDTH;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          ovf;
   logic          pop_btn_q;

   logic flush;
   logic pop_evt;
   logic is_empty;
   logic is_full;
   logic push;
   logic pop;
   logic drop;
   logic [EW-1:0] head;

   assign flush    = rst | bus.clear;
   assign pop_evt  = bus.pop_btn & ~pop_btn_q;
   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == FULL_CNT);

   // A pop in the same cycle frees the slot, so a capture into a full queue still fits.
   assign push = ~flush & bus.capture & (~is_full | pop_evt);
   assign pop  = ~flush & pop_evt & ~is_empty;
   assign drop = ~flush & bus.capture & is_full & ~pop_evt;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.cap_tag, bus.cap_data};
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         pop_btn_q <= bus.pop_btn;
      end else begin
         pop_btn_q <= bus.pop_btn;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   assign head = is_empty ? '0 : mem[rd_ptr];

   assign bus.head_data = head[WIDTH-1:0];
   assign bus.head_tag  = head[EW-1:WIDTH];
   assign bus.count     = cnt;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = ovf;
endmodule

// File: tb/tb_bus_trace_fifo.sv
// Directed bench for bus_trace_fifo: fill/drain, overflow, button hold, simultaneous events, wrap, reset.
module tb_bus_trace_fifo;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   bus_trace_fifo_if #(.DEPTH(8), .WIDTH(16), .TAG_WIDTH(5)) bif ();

   bus_trace_fifo #(.DEPTH(8), .WIDTH(16), .TAG_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [4:0] t);
      bif.capture  = 1'b1;
      bif.cap_data = d;
      bif.cap_tag  = t;
      tick();
      bif.capture  = 1'b0;
   endtask

   task automatic pop_pulse();
      bif.pop_btn = 1'b1;
      tick();
      bif.pop_btn = 1'b0;
      tick();
   endtask

   task automatic expect_pop(input string tag, input logic [15:0] d);
      check(tag, 32'(bif.head_data), 32'(d));
      pop_pulse();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bif.capture  = 1'b0;
      bif.cap_data = 16'h0;
      bif.cap_tag  = 5'h0;
      bif.pop_btn  = 1'b0;
      bif.clear    = 1'b0;

      // Reset held 2 cycles with capture high and button toggling
      rst = 1'b1;
      bif.capture  = 1'b1;
      bif.cap_data = 16'h5555;
      bif.pop_btn  = 1'b1;
      tick();
      bif.pop_btn  = 1'b0;
      tick();
      rst = 1'b0;
      bif.capture = 1'b0;
      check("rst_count", 32'(bif.count), 32'd0);
      check("rst_empty", 32'(bif.empty), 32'd1);
      check("rst_full", 32'(bif.full), 32'd0);
      check("rst_ovf", 32'(bif.overflow), 32'd0);
      check("rst_head_data", 32'(bif.head_data), 32'h0);
      check("rst_head_tag", 32'(bif.head_tag), 32'h0);

      // Fill 0x1111..0x8888 with tags 1..8 on consecutive cycles
      bif.capture = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bif.cap_data = 16'((i + 1) * 16'h1111);
         bif.cap_tag  = 5'(i + 1);
         tick();
         if (i == 0) begin
            check("fill_first_head", 32'(bif.head_data), 32'h1111);
            check("fill_first_count", 32'(bif.count), 32'd1);
         end
      end
      bif.capture = 1'b0;
      check("fill_full", 32'(bif.full), 32'd1);
      check("fill_count", 32'(bif.count), 32'd8);
      check("fill_head_tag", 32'(bif.head_tag), 32'd1);

      // Overflow: capture into full queue without a pop
      push(16'hDEAD, 5'h1F);
      check("ovf_flag", 32'(bif.overflow), 32'd1);
      check("ovf_count", 32'(bif.count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         expect_pop("drain_order", 16'((i + 1) * 16'h1111));
      end
      check("drain_empty", 32'(bif.empty), 32'd1);
      check("drain_head_zero", 32'(bif.head_data), 32'h0);
      check("ovf_sticky", 32'(bif.overflow), 32'd1);
      pop_pulse();
      check("pop_empty_ignored", 32'(bif.count), 32'd0);
      bif.clear = 1'b1;
      tick();
      bif.clear = 1'b0;
      check("clear_ovf", 32'(bif.overflow), 32'd0);
      check("clear_count", 32'(bif.count), 32'd0);

      // Button held 20 cycles with 3 entries queued
      push(16'h0A01, 5'd1);
      push(16'h0A02, 5'd2);
      push(16'h0A03, 5'd3);
      check("hold_pre_count", 32'(bif.count), 32'd3);
      bif.pop_btn = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("hold_count", 32'(bif.count), 32'd2);
      check("hold_head", 32'(bif.head_data), 32'h0A02);
      bif.pop_btn = 1'b0;
      tick();
      expect_pop("hold_drain", 16'h0A02);
      expect_pop("hold_drain", 16'h0A03);
      check("hold_empty", 32'(bif.empty), 32'd1);

      // Simultaneous capture and pop edge while full
      for (int i = 0; i < 8; i++) push(16'(16'h0101 + i), 5'(i));
      bif.capture  = 1'b1;
      bif.cap_data = 16'hAAAA;
      bif.cap_tag  = 5'd9;
      bif.pop_btn  = 1'b1;
      tick();
      bif.capture  = 1'b0;
      bif.pop_btn  = 1'b0;
      tick();
      check("sim_full_count", 32'(bif.count), 32'd8);
      check("sim_full_ovf", 32'(bif.overflow), 32'd0);
      for (int i = 1; i < 8; i++) expect_pop("sim_full_drain", 16'(16'h0101 + i));
      expect_pop("sim_full_last", 16'hAAAA);
      check("sim_full_empty", 32'(bif.empty), 32'd1);

      // Simultaneous capture and pop edge while empty
      bif.capture  = 1'b1;
      bif.cap_data = 16'hAAAA;
      bif.cap_tag  = 5'd3;
      bif.pop_btn  = 1'b1;
      tick();
      bif.capture  = 1'b0;
      bif.pop_btn  = 1'b0;
      tick();
      check("sim_empty_count", 32'(bif.count), 32'd1);
      check("sim_empty_head", 32'(bif.head_data), 32'hAAAA);
      check("sim_empty_tag", 32'(bif.head_tag), 32'd3);
      pop_pulse();

      // Wrap-around from pointers at zero
      bif.clear = 1'b1;
      tick();
      bif.clear = 1'b0;
      for (int i = 0; i < 5; i++) push(16'(16'h2000 + i), 5'(i));
      for (int i = 0; i < 5; i++) expect_pop("wrap_first", 16'(16'h2000 + i));
      for (int i = 0; i < 6; i++) push(16'(16'h3000 + i), 5'(i));
      check("wrap_count", 32'(bif.count), 32'd6);
      for (int i = 0; i < 6; i++) expect_pop("wrap_second", 16'(16'h3000 + i));
      check("wrap_empty", 32'(bif.empty), 32'd1);

      // Clear dominates a same-cycle capture
      push(16'h1234, 5'd1);
      bif.clear    = 1'b1;
      bif.capture  = 1'b1;
      bif.cap_data = 16'h4321;
      tick();
      bif.clear    = 1'b0;
      bif.capture  = 1'b0;
      check("clear_dominates", 32'(bif.count), 32'd0);

      // Mid-operation reset with button held; no spurious pop after release
      push(16'h6666, 5'd6);
      push(16'h6667, 5'd7);
      rst = 1'b1;
      bif.capture = 1'b1;
      bif.pop_btn = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_count", 32'(bif.count), 32'd0);
      bif.cap_data = 16'h7777;
      bif.cap_tag  = 5'd7;
      tick();
      bif.capture = 1'b0;
      tick();
      check("no_spurious_pop", 32'(bif.count), 32'd1);
      check("post_rst_head", 32'(bif.head_data), 32'h7777);
      bif.pop_btn = 1'b0;
      tick();
      expect_pop("post_rst_drain", 16'h7777);
      check("final_empty", 32'(bif.empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
